split_mem_target: RTL and testbench
===================================

// Module: split_mem_target
// PURPOSE
//  Bus-B memory responder: the far end of the bridge initiator's serial-bus transaction.
//  Decodes a window of the bus address space onto an on-chip byte RAM.
//  Writes are acknowledged directly; reads with non-zero latency are SPLIT and returned on split_grant.
//  Instantiated three times on bus B, one per target window.
// PARAMETERS
//  BASE_ADDR     16'h0000  first bus address decoded by this target
//  MEM_DEPTH     4096      bytes of RAM; window is [BASE_ADDR, BASE_ADDR+MEM_DEPTH)
//  READ_LATENCY  4         cycles from address capture to read data ready; 0 = no split
// PORTS
//  clk                      in   1   single clock, all logic on posedge
//  rst                      in   1   synchronous, active-high reset
//  target_addr_in           in   16  bus address
//  target_addr_in_valid     in   1   address strobe, starts a transaction
//  target_data_in           in   8   write data
//  target_data_in_valid     in   1   write data strobe
//  target_rw                in   1   1 = write, 0 = read; sampled with address
//  split_grant              in   1   arbiter grant to return split read data
//  target_ready             out  1   1 = idle, will accept an address
//  target_ack               out  1   1-cycle pulse, transaction complete
//  target_split_ack         out  1   1-cycle pulse, read has been split
//  split_req                out  1   level, split read data pending
//  target_data_out          out  8   read data, valid with target_data_out_valid
//  target_data_out_valid    out  1   1-cycle pulse
//  split_target_last_write  out  8   last byte committed to RAM
// BEHAVIOUR
//  - Reset: every output 0 (target_ready 0 while rst=1, 1 on the first cycle after release); FSM -> IDLE;
//    latency counter cleared; RAM contents are not reset. Reset mid-transaction abandons it with no ack.
//  - Decode: off = addr - BASE_ADDR as 17-bit unsigned. Hit iff addr >= BASE_ADDR and off < MEM_DEPTH.
//  - FSM IDLE->{WAIT_WDATA|WRITE|READ_WAIT|RESP}; READ_WAIT->SPLIT; SPLIT->RESP; WAIT_WDATA->WRITE;
//    WRITE->IDLE; RESP->IDLE. target_ready=1 only in IDLE. Address strobes outside IDLE are ignored.
//  - Miss: on the next cycle, ack=1. For reads, also target_data_out=8'h00 with valid=1.
//    No RAM access. Back to IDLE.
//  - Write hit:
//    - data_valid with the address -> WRITE: RAM[off]<=data, last_write<=data, ack the next cycle.
//    - Otherwise -> WAIT_WDATA until data_valid. No timeout.
//  - Read hit, READ_LATENCY=0: RAM read; data_out + data_out_valid + ack on the cycle after the address.
//  - Read hit, READ_LATENCY>=1:
//    - split_ack pulses on the cycle after the address; enter READ_WAIT.
//    - The counter loads READ_LATENCY and decrements each cycle.
//    - At 0, data is latched and split_req rises (SPLIT). split_req is held until split_grant is seen high.
//    - On the cycle after the grant: split_req=0, data_out valid and ack pulse together.
//  - split_grant outside SPLIT is ignored. Grant on the same cycle split_req first rises is honoured.
//  - Data, ack and split_ack are all registered, never combinational from inputs.
// CONFIGURATION
//  SPLIT_MEM_TARGET_OOR_LOG_EN defined:
//    - Adds oor_addr[15:0] and oor_count[7:0] outputs, both reset to 0.
//    - Each miss latches its address; the counter saturates at 8'hFF.
//  Undefined: ports are absent and misses leave no record; bus behaviour is identical in both cases.
// STRUCTURE
//  split_target_pkg:
//    - typedef enum logic [2:0] split_tgt_state_t with IDLE, WAIT_WDATA, WRITE, READ_WAIT, SPLIT, RESP.
//    - Constants RW_WRITE=1'b1, RW_READ=1'b0.
//    - Function in_window(addr, base, depth).
//  Sub-module split_target_ram: MEM_DEPTH x 8, synchronous write, registered read;
//  instantiated once. FSM and counter stay in split_mem_target.
// TESTING
//  1 Write 0x0123 (BASE 0), data 0xA5 with addr -> ack 1 cycle later, last_write=0xA5, no split_ack.
//  2 Read 0x0123, LATENCY=4 -> split_ack at +1, split_req at +5.
//    Grant at +8 -> data_out=0xA5 valid+ack at +9, split_req low at +9.
//  3 Read 0x1000 (MEM_DEPTH 4096) -> ack + data_out=0x00 valid at +1, no split, RAM unchanged.
//    With the OOR macro: oor_addr=0x1000, oor_count=1.
//  4 Write 0x0010 with data 2 cycles late (0x3C) -> no ack until data, ack 1 cycle after data; readback 0x3C.
//  5 Address strobe during SPLIT plus early split_grant during READ_WAIT -> both ignored;
//    original read completes normally.
//  6 rst pulse in READ_WAIT -> no ack/split_req; target_ready=1 after release; prior RAM data intact.

Source files
------------

// File: rtl/split_target_pkg.sv
// Shared types and helpers for the split-transaction memory target.
//   split_tgt_state_t : target FSM state encoding
//   RW_WRITE/RW_READ  : values of target_rw
//   in_window()       : address window decode
package split_target_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WDATA,
        WRITE,
        READ_WAIT,
        SPLIT,
        RESP
    } split_tgt_state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // The subtraction is done in 17 bits so an address below base cannot wrap into the window.
    function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base,
                                       input int unsigned depth);
        logic [16:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (32'(off) < depth);
    endfunction

endpackage

// File: rtl/split_target_ram.sv
// Byte RAM for the split memory target: synchronous write, registered read. Contents are not reset.
// Ports:
//   clk    in        clock
//   we     in        write enable
//   waddr  in  AW    write address
//   wdata  in  8     write data
//   re     in        read enable; rdata updates on the next edge
//   raddr  in  AW    read address
//   rdata  out 8     registered read data, holds until the next read
module split_target_ram #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/split_mem_target.sv
// Bus-B memory responder. Decodes [BASE_ADDR, BASE_ADDR+MEM_DEPTH) onto a byte RAM. Writes are
// acknowledged directly; reads with READ_LATENCY>0 are split and returned once split_grant is seen.
// Optional feature macro: SPLIT_MEM_TARGET_OOR_LOG_EN adds oor_addr/oor_count miss logging.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   target_addr_in(_valid)   address and strobe that start a transaction (IDLE only)
//   target_data_in(_valid)   write data and strobe
//   target_rw                1 = write, 0 = read, sampled with the address
//   split_grant              permission to return split read data
//   target_ready             idle indicator
//   target_ack               transaction complete pulse
//   target_split_ack         read split pulse
//   split_req                split read data pending
//   target_data_out(_valid)  read data and its pulse
//   split_target_last_write  last byte committed to RAM
//   oor_addr, oor_count      last miss address and saturating miss count (macro only)
module split_mem_target
    import split_target_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'h0000,
    parameter int unsigned MEM_DEPTH    = 4096,
    parameter int unsigned READ_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] target_addr_in,
    input  logic        target_addr_in_valid,
    input  logic [7:0]  target_data_in,
    input  logic        target_data_in_valid,
    input  logic        target_rw,
    input  logic        split_grant,
    output logic        target_ready,
    output logic        target_ack,
    output logic        target_split_ack,
    output logic        split_req,
    output logic [7:0]  target_data_out,
    output logic        target_data_out_valid,
`ifdef SPLIT_MEM_TARGET_OOR_LOG_EN
    output logic [15:0] oor_addr,
    output logic [7:0]  oor_count,
`endif
    output logic [7:0]  split_target_last_write
);

    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;

    split_tgt_state_t state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    off_q, off_d;
    logic             ready_q;
    logic             ack_q, ack_d;
    logic             split_ack_q, split_ack_d;
    logic             dvalid_q, dvalid_d;
    logic             dsel_ram_q, dsel_ram_d;
    logic             split_req_q, split_req_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       last_q, last_d;

    logic [AW-1:0]    off_in;
    logic             hit;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic             ram_re;
    logic [7:0]       ram_rdata;

    assign off_in = AW'(target_addr_in - BASE_ADDR);
    assign hit    = in_window(target_addr_in, BASE_ADDR, MEM_DEPTH);

    split_target_ram #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (target_data_in),
        .re    (ram_re),
        .raddr (off_in),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        ack_d       = 1'b0;
        split_ack_d = 1'b0;
        dvalid_d    = 1'b0;
        dsel_ram_d  = 1'b0;
        split_req_d = split_req_q;
        data_d      = data_q;
        last_d      = last_q;
        ram_we      = 1'b0;
        ram_waddr   = off_q;
        ram_re      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (target_addr_in_valid) begin
                    if (!hit) begin
                        ack_d    = 1'b1;
                        dvalid_d = (target_rw == RW_READ);
                        data_d   = 8'h00;
                        state_d  = RESP;
                    end else if (target_rw == RW_WRITE) begin
                        off_d = off_in;
                        if (target_data_in_valid) begin
                            ram_we    = 1'b1;
                            ram_waddr = off_in;
                            last_d    = target_data_in;
                            ack_d     = 1'b1;
                            state_d   = WRITE;
                        end else begin
                            state_d = WAIT_WDATA;
                        end
                    end else begin
                        // RAM output stays valid until the next read, which only starts from IDLE.
                        ram_re = 1'b1;
                        if (READ_LATENCY == 0) begin
                            ack_d      = 1'b1;
                            dvalid_d   = 1'b1;
                            dsel_ram_d = 1'b1;
                            state_d    = RESP;
                        end else begin
                            split_ack_d = 1'b1;
                            cnt_d       = CW'(READ_LATENCY);
                            state_d     = READ_WAIT;
                        end
                    end
                end
            end
            WAIT_WDATA: begin
                if (target_data_in_valid) begin
                    ram_we  = 1'b1;
                    last_d  = target_data_in;
                    ack_d   = 1'b1;
                    state_d = WRITE;
                end
            end
            READ_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    data_d      = ram_rdata;
                    split_req_d = 1'b1;
                    state_d     = SPLIT;
                end
            end
            SPLIT: begin
                if (split_grant) begin
                    split_req_d = 1'b0;
                    ack_d       = 1'b1;
                    dvalid_d    = 1'b1;
                    state_d     = RESP;
                end
            end
            WRITE, RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            off_q       <= '0;
            ready_q     <= 1'b0;
            ack_q       <= 1'b0;
            split_ack_q <= 1'b0;
            dvalid_q    <= 1'b0;
            dsel_ram_q  <= 1'b0;
            split_req_q <= 1'b0;
            data_q      <= 8'h00;
            last_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            ready_q     <= (state_d == IDLE);
            ack_q       <= ack_d;
            split_ack_q <= split_ack_d;
            dvalid_q    <= dvalid_d;
            dsel_ram_q  <= dsel_ram_d;
            split_req_q <= split_req_d;
            data_q      <= data_d;
            last_q      <= last_d;
        end
    end

    assign target_ready            = ready_q;
    assign target_ack              = ack_q;
    assign target_split_ack        = split_ack_q;
    assign split_req               = split_req_q;
    assign target_data_out_valid   = dvalid_q;
    assign target_data_out         = !dvalid_q ? 8'h00 : (dsel_ram_q ? ram_rdata : data_q);
    assign split_target_last_write = last_q;

`ifdef SPLIT_MEM_TARGET_OOR_LOG_EN
    logic        miss;
    logic [15:0] oor_addr_q;
    logic [7:0]  oor_count_q;

    assign miss = (state_q == IDLE) && target_addr_in_valid && !hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            oor_addr_q  <= 16'h0000;
            oor_count_q <= 8'h00;
        end else if (miss) begin
            oor_addr_q <= target_addr_in;
            if (oor_count_q != 8'hFF) begin
                oor_count_q <= oor_count_q + 8'd1;
            end
        end
    end

    assign oor_addr  = oor_addr_q;
    assign oor_count = oor_count_q;
`endif

endmodule

// File: tb/tb_split_mem_target.sv
module tb_split_mem_target;

    localparam logic [15:0] BASE  = 16'h0000;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic        addr_valid = 1'b0;
    logic [7:0]  wdata = '0;
    logic        wdata_valid = 1'b0;
    logic        rw = 1'b0;
    logic        grant = 1'b0;
    logic        ready, ack, split_ack, sreq, dvalid;
    logic [7:0]  dout, last_write;
`ifdef SPLIT_MEM_TARGET_OOR_LOG_EN
    logic [15:0] oor_addr;
    logic [7:0]  oor_count;
`endif

    split_mem_target #(
        .BASE_ADDR    (BASE),
        .MEM_DEPTH    (DEPTH),
        .READ_LATENCY (LAT)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .target_addr_in          (addr),
        .target_addr_in_valid    (addr_valid),
        .target_data_in          (wdata),
        .target_data_in_valid    (wdata_valid),
        .target_rw               (rw),
        .split_grant             (grant),
        .target_ready            (ready),
        .target_ack              (ack),
        .target_split_ack        (split_ack),
        .split_req               (sreq),
        .target_data_out         (dout),
        .target_data_out_valid   (dvalid),
`ifdef SPLIT_MEM_TARGET_OOR_LOG_EN
        .oor_addr                (oor_addr),
        .oor_count               (oor_count),
`endif
        .split_target_last_write (last_write)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  ref_mem [int];
    logic [15:0] written [$];
    logic [7:0]  exp_last = 8'h00;
    logic [15:0] exp_oor_addr = 16'h0000;
    int          exp_oor_count = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_hit(input int a);
        return (a >= int'(BASE)) && (a - int'(BASE) < DEPTH);
    endfunction

    task automatic note_miss(input logic [15:0] a);
        exp_oor_addr = a;
        if (exp_oor_count < 255) exp_oor_count++;
    endtask

    task automatic chk_oor();
`ifdef SPLIT_MEM_TARGET_OOR_LOG_EN
        chk("oor_addr", oor_addr, exp_oor_addr);
        chk("oor_count", {8'h00, oor_count}, 16'(exp_oor_count));
`endif
    endtask

    // late = number of cycles the write data trails the address (0 = together)
    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int late);
        bit h;
        h = model_hit(int'(a));
        addr = a; rw = 1'b1; addr_valid = 1'b1; wdata = d; wdata_valid = (late == 0);
        step();
        addr_valid = 1'b0; wdata_valid = 1'b0;
        if (h && late > 0) begin
            for (int k = 1; k < late; k++) begin
                chk("wr_wait_ack", ack, 1'b0);
                chk("wr_wait_ready", ready, 1'b0);
                step();
            end
            chk("wr_wait_ack", ack, 1'b0);
            wdata = d; wdata_valid = 1'b1;
            step();
            wdata_valid = 1'b0;
        end
        if (h) begin
            ref_mem[int'(a)] = d;
            written.push_back(a);
            exp_last = d;
        end else begin
            note_miss(a);
        end
        chk("wr_ack", ack, 1'b1);
        chk("wr_split_ack", split_ack, 1'b0);
        chk("wr_dvalid", dvalid, 1'b0);
        chk("wr_last", last_write, exp_last);
        chk_oor();
        step();
        chk("wr_ack_pulse", ack, 1'b0);
        chk("wr_ready", ready, 1'b1);
    endtask

    // gd = cycles after split_req rises before grant; early = grant during the wait;
    // stray = an address strobe while the read is split
    task automatic do_read(input logic [15:0] a, input int gd, input bit early, input bit stray);
        logic [7:0] exp_d;
        addr = a; rw = 1'b0; addr_valid = 1'b1;
        step();
        addr_valid = 1'b0;
        if (!model_hit(int'(a))) begin
            note_miss(a);
            chk("rdm_ack", ack, 1'b1);
            chk("rdm_dvalid", dvalid, 1'b1);
            chk("rdm_data", dout, 8'h00);
            chk("rdm_split_ack", split_ack, 1'b0);
            chk_oor();
            step();
            chk("rdm_ready", ready, 1'b1);
            chk("rdm_ack_pulse", ack, 1'b0);
            return;
        end
        exp_d = ref_mem[int'(a)];
        chk("rd_split_ack", split_ack, 1'b1);
        chk("rd_ack_early", ack, 1'b0);
        chk("rd_sreq_early", sreq, 1'b0);
        if (early) grant = 1'b1;
        for (int c = 2; c <= LAT; c++) begin
            step();
            chk("rd_wait_split_ack", split_ack, 1'b0);
            chk("rd_wait_sreq", sreq, 1'b0);
            chk("rd_wait_ack", ack, 1'b0);
        end
        grant = 1'b0;
        step();
        chk("rd_sreq_rise", sreq, 1'b1);
        chk("rd_sreq_ack", ack, 1'b0);
        for (int k = 0; k < gd; k++) begin
            if (stray && k == 0) begin
                addr = 16'($urandom_range(0, 16'hFFFF)); rw = 1'($urandom_range(0, 1));
                addr_valid = 1'b1; wdata = 8'($urandom); wdata_valid = 1'b1;
            end
            step();
            addr_valid = 1'b0; wdata_valid = 1'b0;
            chk("rd_hold_sreq", sreq, 1'b1);
            chk("rd_hold_ack", ack, 1'b0);
            chk("rd_hold_split_ack", split_ack, 1'b0);
        end
        grant = 1'b1;
        step();
        grant = 1'b0;
        chk("rd_ack", ack, 1'b1);
        chk("rd_dvalid", dvalid, 1'b1);
        chk("rd_data", dout, exp_d);
        chk("rd_sreq_fall", sreq, 1'b0);
        step();
        chk("rd_ready", ready, 1'b1);
        chk("rd_ack_pulse", ack, 1'b0);
        chk("rd_last", last_write, exp_last);
        chk_oor();
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_ready", ready, 1'b0);
        chk("rst_ack", ack, 1'b0);
        chk("rst_split_ack", split_ack, 1'b0);
        chk("rst_sreq", sreq, 1'b0);
        chk("rst_dvalid", dvalid, 1'b0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_last", last_write, 8'h00);
        chk_oor();
        rst = 1'b0;
        step();
        chk("rel_ready", ready, 1'b1);

        // 1: write with data alongside the address
        do_write(16'h0123, 8'hA5, 0);
        // 2: split read, grant three cycles after split_req rises
        do_read(16'h0123, 3, 1'b0, 1'b0);
        // 3: read miss just past the window; RAM offset 0 untouched
        do_write(16'h0000, 8'h5A, 0);
        do_read(16'h1000, 0, 1'b0, 1'b0);
        do_read(16'h0000, 0, 1'b0, 1'b0);
        // 4: write data two cycles late
        do_write(16'h0010, 8'h3C, 2);
        do_read(16'h0010, 1, 1'b0, 1'b0);
        // 5: early grant during the wait plus a stray strobe while split
        do_read(16'h0123, 2, 1'b1, 1'b1);
        // Boundaries: last byte of window, grant when split_req first rises
        do_write(16'h0FFF, 8'hC3, 1);
        do_read(16'h0FFF, 0, 1'b0, 1'b0);
        do_write(16'hFFFF, 8'h11, 0);

        // 6: reset while the read is waiting
        addr = 16'h0123; rw = 1'b0; addr_valid = 1'b1;
        step();
        addr_valid = 1'b0;
        chk("rst6_split_ack", split_ack, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst6_ready_in_rst", ready, 1'b0);
        chk("rst6_ack", ack, 1'b0);
        step();
        chk("rst6_ready_rel", ready, 1'b1);
        for (int c = 0; c < LAT + 2; c++) begin
            chk("rst6_no_sreq", sreq, 1'b0);
            chk("rst6_no_ack", ack, 1'b0);
            step();
        end
        exp_last = 8'h00;
        exp_oor_addr = 16'h0000;
        exp_oor_count = 0;
        do_read(16'h0123, 1, 1'b0, 1'b0);

        // Randomised traffic against the model
        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            bit miss;
            miss = ($urandom_range(0, 4) == 0);
            if (miss) a = 16'($urandom_range(16'hFFFF, DEPTH));
            else a = 16'($urandom_range(DEPTH - 1, 0));
            if ($urandom_range(0, 1) == 1 || written.size() == 0) begin
                do_write(a, 8'($urandom), int'($urandom_range(0, 3)));
            end else begin
                int gd;
                if (!miss) a = written[$urandom_range(0, written.size() - 1)];
                gd = int'($urandom_range(0, 4));
                do_read(a, gd, 1'($urandom_range(0, 1)), (gd > 0) && ($urandom_range(0, 1) == 1));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
